// File: rtl/aes_kexp_seq_pkg.sv
// Shared AES key-schedule constants and wire-level types.
// aes_const carries the round/word-count helpers; aes_wire the word and state typedefs.
package aes_const;

  localparam int Nb = 4;
  localparam logic [7:0] RCON_SEED = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  function automatic int nw_of(input int nk);
    return Nb * (nr_of(nk) + 1);
  endfunction

  // GF(2^8) multiply by x, reduced by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

package aes_wire;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] rkey_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_DONE
  } kexp_state_e;

endpackage

// File: rtl/aes_kexp_seq_subword.sv
// SubWord: four parallel AES S-box lookups on one 32-bit word.
// The table is packed with entry 0x00 in the top byte.
module aes_subword
  import aes_wire::*;
(
  input  word_t word_i,
  output word_t word_o
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    logic [7:0] b;
    assign b = word_i[8*gi +: 8];
    // Entry b sits at bit offset 8*(255-b), i.e. {~b, 3'b000}.
    assign word_o[8*gi +: 8] = SBOX[{~b, 3'b000} +: 8];
  end

endmodule

// File: rtl/aes_kexp_seq.sv
// Iterative AES key expansion: one schedule word per clock into a word store,
// with a shared SubWord path and an indexed round-key read port.
module aes_kexp_seq
  import aes_const::*;
  import aes_wire::*;
#(
  parameter int Nk = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            KeyValid,
  output logic            KeyReady,
  input  logic [32*Nk-1:0] Key,
  output logic            Busy,
  output logic            KValid,
  input  logic [3:0]      RoundIdx,
  output rkey_t           RoundKey
);

  localparam int Nr = nr_of(Nk);
  localparam int NW = nw_of(Nk);
  localparam int IW = $clog2(NW);
  localparam int JW = $clog2(Nk);
  localparam logic [JW-1:0] J_LAST = JW'(Nk - 1);
  localparam logic [JW-1:0] J_HALF = JW'(Nk / 2);
  localparam logic [3:0]    NR_IDX = 4'(Nr);

  if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
    $error("aes_kexp_seq: Nk must be 4, 6 or 8");
  end

  kexp_state_e    state_q, state_d;
  logic [IW-1:0]  i_q, i_d;
  logic [JW-1:0]  j_q, j_d;
  logic [7:0]     rcon_q, rcon_d;
  logic           kvalid_q, kvalid_d;
  logic           wr_en;
  logic           accept;

  word_t          w_q [NW];
  word_t          prev_w, back_w, sub_in, sub_out, t_w, new_w;
  logic [IW-1:0]  prev_idx, back_idx, rk_base;
  logic           rk_sel;

  assign KeyReady = reset && (state_q != ST_EXPAND);
  assign accept   = KeyValid && KeyReady;
  assign Busy     = (state_q == ST_EXPAND);
  assign KValid   = kvalid_q;

  // Indices are parked at 0 outside EXPAND so they never leave the store.
  assign prev_idx = Busy ? i_q - IW'(1)  : '0;
  assign back_idx = Busy ? i_q - IW'(Nk) : '0;
  assign prev_w   = w_q[prev_idx];
  assign back_w   = w_q[back_idx];

  assign sub_in = (j_q == '0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

  aes_subword u_subword (
    .word_i (sub_in),
    .word_o (sub_out)
  );

  always_comb begin
    t_w = prev_w;
    if (j_q == '0) begin
      t_w = sub_out ^ {rcon_q, 24'h0};
    end else if (Nk == 8 && j_q == J_HALF) begin
      t_w = sub_out;
    end
  end

  assign new_w = back_w ^ t_w;

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    rcon_d   = rcon_q;
    kvalid_d = kvalid_q;
    wr_en    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d  = ST_EXPAND;
          i_d      = IW'(Nk);
          j_d      = '0;
          rcon_d   = RCON_SEED;
          kvalid_d = 1'b0;
        end
      end
      ST_EXPAND: begin
        wr_en = 1'b1;
        i_d   = i_q + IW'(1);
        j_d   = (j_q == J_LAST) ? '0 : j_q + JW'(1);
        if (j_q == '0) begin
          rcon_d = xtime(rcon_q);
        end
        if (i_q == IW'(NW - 1)) begin
          state_d  = ST_DONE;
          kvalid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      rcon_q   <= RCON_SEED;
      kvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      rcon_q   <= rcon_d;
      kvalid_q <= kvalid_d;
    end
  end

  // The store is deliberately left uninitialised; KValid gates every read.
  always_ff @(posedge clock) begin
    if (accept) begin
      for (int k = 0; k < Nk; k++) begin
        w_q[k] <= Key[32*(Nk-k)-1 -: 32];
      end
    end else if (wr_en) begin
      w_q[i_q] <= new_w;
    end
  end

  assign rk_sel  = (RoundIdx <= NR_IDX);
  assign rk_base = rk_sel ? IW'({RoundIdx, 2'b00}) : '0;

  always_comb begin
    RoundKey = '0;
    if (kvalid_q && rk_sel) begin
      RoundKey = {w_q[rk_base], w_q[rk_base + IW'(1)],
                  w_q[rk_base + IW'(2)], w_q[rk_base + IW'(3)]};
    end
  end

endmodule

// File: tb/tb_aes_kexp_seq.sv
// Directed bench for aes_kexp_seq: FIPS-197 vectors for Nk=4/6/8, key
// hold-off during expansion, and asynchronous reset mid-expansion.
module tb_aes_kexp_seq;
  import aes_wire::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic kv4 = 1'b0, kv6 = 1'b0, kv8 = 1'b0;
  logic kr4, kr6, kr8;
  logic busy4, busy6, busy8;
  logic kval4, kval6, kval8;
  logic [3:0]   ridx = 4'd0;
  logic [127:0] key4;
  logic [191:0] key6;
  logic [255:0] key8;
  rkey_t rk4, rk6, rk8;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] K4      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K6      = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K8      = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK10_K4 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RK10_Z  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_kexp_seq #(.Nk(4)) u4 (
    .clock(clk), .reset(rst_n), .KeyValid(kv4), .KeyReady(kr4), .Key(key4),
    .Busy(busy4), .KValid(kval4), .RoundIdx(ridx), .RoundKey(rk4)
  );
  aes_kexp_seq #(.Nk(6)) u6 (
    .clock(clk), .reset(rst_n), .KeyValid(kv6), .KeyReady(kr6), .Key(key6),
    .Busy(busy6), .KValid(kval6), .RoundIdx(ridx), .RoundKey(rk6)
  );
  aes_kexp_seq #(.Nk(8)) u8 (
    .clock(clk), .reset(rst_n), .KeyValid(kv8), .KeyReady(kr8), .Key(key8),
    .Busy(busy8), .KValid(kval8), .RoundIdx(ridx), .RoundKey(rk8)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic kval_sel(input int nk);
    case (nk)
      4: return kval4;
      6: return kval6;
      default: return kval8;
    endcase
  endfunction

  function automatic logic busy_sel(input int nk);
    case (nk)
      4: return busy4;
      6: return busy6;
      default: return busy8;
    endcase
  endfunction

  function automatic logic ready_sel(input int nk);
    case (nk)
      4: return kr4;
      6: return kr6;
      default: return kr8;
    endcase
  endfunction

  task automatic set_kv(input int nk, input logic v);
    case (nk)
      4: kv4 = v;
      6: kv6 = v;
      default: kv8 = v;
    endcase
  endtask

  // Latency counts the accept edge as edge 1, up to the edge KValid rises on.
  task automatic load_and_wait(input int nk, output int lat);
    @(negedge clk);
    check($sformatf("ready_idle_nk%0d", nk), 128'(ready_sel(nk)), 128'd1);
    set_kv(nk, 1'b1);
    @(posedge clk); #1;
    set_kv(nk, 1'b0);
    lat = 1;
    check($sformatf("busy_after_accept_nk%0d", nk), 128'(busy_sel(nk)), 128'd1);
    check($sformatf("kvalid_after_accept_nk%0d", nk), 128'(kval_sel(nk)), 128'd0);
    while (!kval_sel(nk) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("busy_done_nk%0d", nk), 128'(busy_sel(nk)), 128'd0);
  endtask

  initial begin
    int  lat;
    logic saw_ready;
    key4 = K4;
    key6 = K6;
    key8 = K8;

    // Reset state
    #12;
    check("reset_keyready", 128'(kr4), 128'd0);
    check("reset_busy", 128'(busy4), 128'd0);
    check("reset_kvalid", 128'(kval4), 128'd0);
    check("reset_roundkey", rk4, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_keyready", 128'(kr8), 128'd1);
    check("idle_roundkey_zero", rk6, 128'd0);

    // Nk=4
    load_and_wait(4, lat);
    check("latency_nk4", 128'(lat), 128'd41);
    ridx = 4'd0; #1;
    check("nk4_round0", rk4, K4);
    ridx = 4'd1; #1;
    check("nk4_w4", 128'(rk4[127:96]), 128'h a0fafe17);
    ridx = 4'd10; #1;
    check("nk4_round10", rk4, RK10_K4);
    ridx = 4'd11; #1;
    check("nk4_round11_zero", rk4, 128'd0);

    // Nk=6
    load_and_wait(6, lat);
    check("latency_nk6", 128'(lat), 128'd47);
    ridx = 4'd1; #1;
    check("nk6_w6", 128'(rk6[63:32]), 128'h fe0c91f7);
    ridx = 4'd12; #1;
    check("nk6_w51", 128'(rk6[31:0]), 128'h01002202);
    ridx = 4'd13; #1;
    check("nk6_round13_zero", rk6, 128'd0);

    // Nk=8
    load_and_wait(8, lat);
    check("latency_nk8", 128'(lat), 128'd53);
    ridx = 4'd2; #1;
    check("nk8_w8", 128'(rk8[127:96]), 128'h9ba35411);
    ridx = 4'd14; #1;
    check("nk8_w59", 128'(rk8[31:0]), 128'h706c631e);
    ridx = 4'd15; #1;
    check("nk8_round15_zero", rk8, 128'd0);

    // Second key offered during EXPAND is held off, then taken on the first DONE cycle
    ridx = 4'd10;
    @(negedge clk);
    key4 = K4;
    kv4  = 1'b1;
    @(posedge clk); #1;
    key4 = 128'd0;
    check("hold_kvalid_drop", 128'(kval4), 128'd0);
    saw_ready = 1'b0;
    lat = 1;
    while (!kval4 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (!kval4 && kr4) saw_ready = 1'b1;
    end
    check("hold_ready_low", 128'(saw_ready), 128'd0);
    check("hold_latency", 128'(lat), 128'd41);
    check("hold_first_round10", rk4, RK10_K4);
    check("hold_ready_done", 128'(kr4), 128'd1);
    @(posedge clk); #1;
    kv4 = 1'b0;
    check("hold_reaccept_kvalid", 128'(kval4), 128'd0);
    check("hold_reaccept_busy", 128'(busy4), 128'd1);
    lat = 1;
    while (!kval4 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("hold_second_round10", rk4, RK10_Z);

    // Asynchronous reset in the middle of EXPAND
    @(negedge clk);
    key4 = K4;
    kv4  = 1'b1;
    @(posedge clk); #1;
    kv4 = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    check("midreset_busy_before", 128'(busy4), 128'd1);
    rst_n = 1'b0;
    #1;
    check("midreset_busy", 128'(busy4), 128'd0);
    check("midreset_kvalid", 128'(kval4), 128'd0);
    check("midreset_keyready", 128'(kr4), 128'd0);
    check("midreset_roundkey", rk4, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    load_and_wait(4, lat);
    check("reload_latency", 128'(lat), 128'd41);
    ridx = 4'd10; #1;
    check("reload_round10", rk4, RK10_K4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_kexp_seq.md
Name: aes_kexp_seq

Overview:
- Iterative, area-reduced AES key-schedule controller. It produces one expanded key word per clock into an internal word store, using a single 4-byte SubWord path.
- Replaces the fully-unrolled combinational expansion wherever area matters. The cipher round sequencer reads round keys by index through a read port.
- Handles a valid/ready key-load handshake, expansion sequencing, Rcon generation, and a RoundKey-valid flag.

Parameters:
- Nk, 4, key length in 32-bit words (legal values 4, 6, 8; any other value fails elaboration).
- Nb, 4, state columns, fixed.
- Nr, Nk+6, number of rounds (derived; not to be overridden).
- NW, Nb*(Nr+1), total expanded words (44, 52 or 60).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- KeyValid  in  1  Key holds a new cipher key.
- KeyReady  out  1  block accepts a key this cycle.
- Key  in  8 x 4*Nk  key bytes, byte 0 = MSB of w[0].
- Busy  out  1  expansion in progress.
- KValid  out  1  all NW words valid.
- RoundIdx  in  4  round-key index 0..Nr.
- RoundKey  out  128  {w[4r],w[4r+1],w[4r+2],w[4r+3]}, w[4r] in bits 127:96.

Behaviour:
- Reset (async assert, sync deassert by caller): state=IDLE, word index i=0, rcon=0x01, KeyReady=0 during reset, Busy=0, KValid=0. Word store is not cleared. RoundKey is 0 while KValid=0.
- States are IDLE, EXPAND and DONE. KeyReady=1 in IDLE and DONE and 0 in EXPAND. A key offered during EXPAND is held off, not dropped.
- Accept means KeyValid&KeyReady at a rising edge. On accept:
  - w[0..Nk-1] is loaded from Key.
  - i is set to Nk and rcon to 0x01.
  - KValid goes to 0 and state goes to EXPAND, all on the same edge.
- EXPAND writes exactly one word per cycle:
  - t = w[i-1].
  - If i%Nk==0: t = SubWord(RotWord(t)) ^ {rcon,24'h0}, then rcon = xtime(rcon) (shift left 1; XOR 0x1b if bit 7 was set).
  - Else if Nk==8 and i%Nk==4: t = SubWord(t).
  - Then w[i] = w[i-Nk]^t and i increments.
- i%Nk is tracked with a modulo counter j (0..Nk-1), not a divider. w[i-1] and w[i-Nk] come from the store; one read of each per cycle.
- EXPAND lasts NW-Nk cycles: 40 for Nk=4, 46 for Nk=6, 52 for Nk=8. After the cycle that writes w[NW-1], state=DONE and KValid=1, both registered.
- Latency from the accept edge to KValid=1 is NW-Nk+1 edges. Busy=1 exactly while state==EXPAND.
- DONE holds KValid=1 until the next accept or reset. An accept in DONE restarts expansion; KValid drops on that same edge.
- The RoundKey read is combinational from RoundIdx and the store. If RoundIdx>Nr or KValid==0, RoundKey=0.
- The last rcon used is 0x36 (Nk=4), 0x80 (Nk=6) or 0x40 (Nk=8). The xtime wrap after 0x80 is never consumed for legal Nk.
- If reset asserts mid-EXPAND, the block returns to IDLE immediately and KValid=0. The partial key is discarded and the next key restarts from w[0].
- KeyValid held high across DONE re-accepts every cycle that KeyReady=1. The caller must drop KeyValid after the handshake.

Decomposition:
- aes_const package holds Nb and the Nr(Nk) and NW helpers, plus the Rcon seed 8'h01 and the reduction polynomial 8'h1b.
- aes_wire package holds the typedefs word_t (logic[31:0]) and rkey_t (logic[127:0]).
- Sub-module aes_subword (combinational): four SBox byte lookups on a 32-bit word. It is instantiated once and is shared by both the RotWord and Nk=8 paths.
- The word store is a flat register array of NW word_t with one write port and three read paths (i-1, i-Nk, round read).

Test Plan:
- Nk=4, key 2b7e151628aed2a6abf7158809cf4f3c:
  - w[4]=a0fafe17.
  - KValid rises 41 edges after accept.
  - RoundIdx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
- Nk=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - w[6]=fe0c91f7 and w[51]=01002202.
  - Latency is 47 edges.
  - RoundIdx=13 gives 0.
- Nk=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - w[8]=9ba35411 and w[59]=706c631e.
  - Latency is 53 edges.
- Offer a second key during EXPAND: KeyReady stays 0, the first key's schedule completes unchanged, and the second key is accepted on the first DONE cycle with KValid falling on that edge.
- Assert reset at EXPAND cycle 20: Busy=0 and KValid=0 asynchronously. A re-load of the Nk=4 vector then yields the correct round-10 key.
